// File: rtl/imm_extend_stage_if.sv
// rtl/imm_extend_stage_if.sv - valid/ready bus carrying raw immediates in and extended immediates out
interface imm_extend_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [1:0]       out_mode;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_imm, out_mode
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_imm, out_mode
    );
endinterface

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - registered immediate extension with one-entry skid buffer
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    imm_extend_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_imm_q, out_imm_d;
    logic [1:0]       out_mode_q, out_mode_d;
    logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
    logic [1:0]       skid_mode_q, skid_mode_d;

    logic [OUT_W-1:0] sext, zext, ext_imm;
    logic             accept, consume;

    always_comb begin
        sext              = {OUT_W{bus.in_imm[IN_W-1]}};
        sext[IN_W-1:0]    = bus.in_imm;
        zext              = '0;
        zext[IN_W-1:0]    = bus.in_imm;
        case (bus.in_mode)
            2'b00:   ext_imm = sext;
            2'b01:   ext_imm = zext;
            2'b10:   ext_imm = zext << IN_W;
            default: ext_imm = sext << 2;
        endcase
    end

    // in_ready comes only from state and rst so out_ready never reaches it combinationally
    assign bus.in_ready  = (state_q != ST_FULL) && !rst;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_imm   = out_imm_q;
    assign bus.out_mode  = out_mode_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        out_imm_d   = out_imm_q;
        out_mode_d  = out_mode_q;
        skid_imm_d  = skid_imm_q;
        skid_mode_d = skid_mode_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d    = ST_ONE;
                        out_imm_d  = ext_imm;
                        out_mode_d = bus.in_mode;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_imm_d  = ext_imm;
                        out_mode_d = bus.in_mode;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_imm_d  = ext_imm;
                        skid_mode_d = bus.in_mode;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d    = ST_ONE;
                        out_imm_d  = skid_imm_q;
                        out_mode_d = skid_mode_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_imm_q   <= '0;
            out_mode_q  <= '0;
            skid_imm_q  <= '0;
            skid_mode_q <= '0;
        end else begin
            state_q     <= state_d;
            out_imm_q   <= out_imm_d;
            out_mode_q  <= out_mode_d;
            skid_imm_q  <= skid_imm_d;
            skid_mode_q <= skid_mode_d;
        end
    end
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - scoreboard bench for imm_extend_stage at 16/32 and 8/16 widths
module tb_imm_extend_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    imm_extend_stage_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_extend_stage_if #(.IN_W(8),  .OUT_W(16)) nbus ();

    imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );
    imm_extend_stage #(.IN_W(8), .OUT_W(16)) dut_n (
        .clk(clk), .rst(rst), .flush(1'b0), .bus(nbus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_pops = 0;
    logic [33:0] sb[$];

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            2'b00:   return {{16{imm[15]}}, imm};
            2'b01:   return {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    task automatic drive_cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                               input logic rdy, input logic fl, input logic [31:0] exp,
                               output logic acc);
        logic cons;
        logic [33:0] e;
        bus.in_valid  = v;
        bus.in_imm    = imm;
        bus.in_mode   = mode;
        bus.out_ready = rdy;
        flush         = fl;
        #1;
        acc  = v && bus.in_ready;
        cons = bus.out_valid && rdy;
        if (cons && !fl) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_imm=%h mode=%0d with nothing expected", bus.out_imm, bus.out_mode);
            end else begin
                e = sb.pop_front();
                n_pops++;
                if ({bus.out_mode, bus.out_imm} !== e) begin
                    errors++;
                    $display("FAIL sb_data: got mode=%0d imm=%h, want mode=%0d imm=%h",
                             bus.out_mode, bus.out_imm, e[33:32], e[31:0]);
                end
            end
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back({mode, exp});
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 10 && sb.size() > 0; i++) drive_cycle(0, 16'h0, 2'b00, 1, 0, 32'h0, a);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, want 0", sb.size());
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_imm=%h in_ready=%b, want 0 0 0",
                     bus.out_valid, bus.out_imm, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_sext();
        logic a;
        drive_cycle(1, 16'h8000, 2'b00, 1, 0, 32'hFFFF8000, a);
        checks++;
        if (a !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_imm !== 32'hFFFF8000) begin
            errors++;
            $display("FAIL sext_latency: acc=%b out_valid=%b out_imm=%h, want 1 1 ffff8000",
                     a, bus.out_valid, bus.out_imm);
        end
        drain();
    endtask

    task automatic test_modes();
        logic a;
        drive_cycle(1, 16'h8000, 2'b01, 1, 0, 32'h00008000, a);
        drive_cycle(1, 16'h1234, 2'b10, 1, 0, 32'h12340000, a);
        drive_cycle(1, 16'hFFFF, 2'b11, 1, 0, 32'hFFFFFFFC, a);
        drive_cycle(1, 16'h0001, 2'b11, 1, 0, 32'h00000004, a);
        drain();
    endtask

    task automatic fill_full();
        logic a1, a2;
        drive_cycle(1, 16'h0001, 2'b01, 0, 0, 32'h00000001, a1);
        drive_cycle(1, 16'h0002, 2'b01, 0, 0, 32'h00000002, a2);
        checks++;
        if (a1 !== 1'b1 || a2 !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_imm !== 32'h1) begin
            errors++;
            $display("FAIL bp_full: acc=%b%b in_ready=%b out_imm=%h, want 11 0 00000001",
                     a1, a2, bus.in_ready, bus.out_imm);
        end
    endtask

    task automatic test_backpressure();
        logic a;
        fill_full();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1, 16'h0003, 2'b01, 0, 0, 32'h00000003, a);
            checks++;
            if (a !== 1'b0 || bus.out_imm !== 32'h1 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: acc=%b out_valid=%b out_imm=%h, want 0 1 00000001",
                         a, bus.out_valid, bus.out_imm);
            end
        end
        drive_cycle(0, 16'h0, 2'b00, 1, 0, 32'h0, a);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_imm !== 32'h2) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_imm=%h, want 1 00000002", bus.in_ready, bus.out_imm);
        end
        drain();
    endtask

    task automatic test_streaming();
        logic a;
        logic [15:0] imm;
        logic [1:0] mode;
        int start_pops;
        start_pops = n_pops;
        for (int i = 0; i < 8; i++) begin
            imm  = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            drive_cycle(1, imm, mode, 1, 0, model(imm, mode), a);
            checks++;
            if (a !== 1'b1 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d: acc=%b out_valid=%b, want 1 1", i, a, bus.out_valid);
            end
        end
        drain();
        checks++;
        if (n_pops - start_pops != 8) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs, want 8", n_pops - start_pops);
        end
    endtask

    task automatic test_flush();
        logic a;
        fill_full();
        drive_cycle(1, 16'h0055, 2'b00, 1, 1, 32'h00000055, a);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 16'h0, 2'b00, 1, 0, 32'h0, a);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak: out_valid=%b out_imm=%h, want 0", bus.out_valid, bus.out_imm);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill_full();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b out_imm=%h in_ready=%b, want 0 0 0",
                     bus.out_valid, bus.out_imm, bus.in_ready);
        end
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        test_sext();
    endtask

    task automatic test_narrow();
        logic [7:0]  imms[3]  = '{8'h80, 8'h12, 8'hFF};
        logic [1:0]  modes[3] = '{2'b00, 2'b10, 2'b11};
        logic [15:0] exps[3]  = '{16'hFF80, 16'h1200, 16'hFFFC};
        for (int i = 0; i < 3; i++) begin
            nbus.in_valid  = 1'b1;
            nbus.in_imm    = imms[i];
            nbus.in_mode   = modes[i];
            nbus.out_ready = 1'b1;
            @(negedge clk);
            nbus.in_valid = 1'b0;
            checks++;
            if (nbus.out_valid !== 1'b1 || nbus.out_imm !== exps[i] || nbus.out_mode !== modes[i]) begin
                errors++;
                $display("FAIL narrow%0d: out_valid=%b out_imm=%h, want 1 %h",
                         i, nbus.out_valid, nbus.out_imm, exps[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_imm     = '0;
        bus.in_mode    = '0;
        bus.out_ready  = 1'b0;
        nbus.in_valid  = 1'b0;
        nbus.in_imm    = '0;
        nbus.in_mode   = '0;
        nbus.out_ready = 1'b0;
        test_reset();
        test_sext();
        test_modes();
        test_backpressure();
        test_streaming();
        test_flush();
        test_reset_mid();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
